// File: rtl/lsu_mem_port_pkg.sv
// Shared width codes, FSM states and decode helpers for the LSU memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN is consumed by lsu_mem_port.
package lsu_mem_port_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    if (we) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) ||
           (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) ||
           (f3 == F3_LW) || (f3 == F3_LBU) ||
           (f3 == F3_LHU);
    end
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (f3[1:0] == 2'b01): m = off[0];
      (f3[1:0] == 2'b10): m = |off;
      default:            m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_port_store_lane.sv
// Store lane: byte enables and lane-replicated write data
// for byte, halfword and word stores.
module lsu_store_lane (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] data
);

  always_comb begin
    be   = 4'hF;
    data = wdata;
    unique case (1'b1)
      (size == 2'b00): begin
        be   = 4'b0001 << off;
        data = {4{wdata[7:0]}};
      end
      (size == 2'b01): begin
        be   = 4'b0011 << {off[1], 1'b0};
        data = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'hF;
        data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store bus port: one access per handshake, shifted load data out.
// LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of clearing bits.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          ld_valid,
  output logic [31:0]   ld_data,
  output logic [2:0]    ld_funct3,
  output logic          st_done,
  output logic          err,
  output logic          busy
);

  lsu_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ld_valid_q, ld_valid_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic          st_done_q, st_done_d;
  logic          err_q, err_d;

  logic [1:0]    off_eff;
  logic          reject;
  logic [3:0]    lane_be;
  logic [31:0]   lane_data;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    off_eff = req_addr[1:0];
    reject  = !f3_legal(req_we, req_funct3) ||
              misaligned(req_funct3, req_addr[1:0]);
  end
`else
  // Misaligned low bits are dropped so the access snaps to its natural boundary.
  always_comb begin
    off_eff = req_addr[1:0];
    unique case (1'b1)
      (req_funct3[1:0] == 2'b01): off_eff = {req_addr[1], 1'b0};
      (req_funct3[1:0] == 2'b10): off_eff = 2'b00;
      default:                    off_eff = req_addr[1:0];
    endcase
    reject = !f3_legal(req_we, req_funct3);
  end
`endif

  lsu_store_lane u_lane (
    .size  (req_funct3[1:0]),
    .off   (off_eff),
    .wdata (req_wdata),
    .be    (lane_be),
    .data  (lane_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    ld_f3_d    = ld_f3_q;
    ld_valid_d = 1'b0;
    st_done_d  = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = off_eff;
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            addr_d  = {req_addr[AW-1:2], 2'b00};
            be_d    = req_we ? lane_be : 4'hF;
            wdata_d = req_we ? lane_data : 32'h0;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            state_d   = ST_IDLE;
            st_done_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d    = ST_IDLE;
          ld_valid_d = 1'b1;
          ld_data_d  = mem_rdata >> {off_q, 3'b000};
          ld_f3_d    = f3_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      addr_q     <= '0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'h0;
      ld_f3_q    <= 3'b000;
      st_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      ld_f3_q    <= ld_f3_d;
      st_done_q  <= st_done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = !req_ready;
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign ld_funct3 = ld_f3_q;
  assign st_done   = st_done_q;
  assign err       = err_q;

endmodule
